// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream instruction memory loader; optional checksum stage via IMEM_LOADER_CKSUM_EN
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        err
);

`ifdef IMEM_LOADER_CKSUM_EN
  typedef enum logic [2:0] {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CKSUM, ST_RUN, ST_ERROR} state_t;
  localparam state_t ST_AFTER_DATA = ST_CKSUM;
`else
  typedef enum logic [2:0] {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_RUN, ST_ERROR} state_t;
  localparam state_t ST_AFTER_DATA = ST_RUN;
`endif

  // Largest word count that fits the instruction memory.
  localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

  state_t            state;
  state_t            state_nx;
  logic              armed;
  logic              accept;
  logic [7:0]        len_lo;
  logic [15:0]       n_len;
  logic [1:0]        byte_cnt;
  logic [23:0]       shreg;
  logic [ADDR_W-1:0] word_index;
  logic [ADDR_W-1:0] last_idx;
  logic              last_word;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]        csum;
`endif

  assign n_len     = {in_data, len_lo};
  // armed keeps in_ready low until the first edge after reset is released.
  assign in_ready  = armed && (state != ST_RUN) && (state != ST_ERROR);
  assign accept    = in_valid && in_ready;
  assign last_word = (byte_cnt == 2'd3) && (word_index == last_idx);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_LEN_LO;
    else        state <= state_nx;
  end

  // Next-state and status outputs; cpu_reset stays high through the final write strobe.
  always_comb begin
    state_nx  = state;
    done      = 1'b0;
    err       = 1'b0;
    cpu_reset = 1'b1;
    case (state)
      ST_LEN_LO: if (accept) state_nx = ST_LEN_HI;
      ST_LEN_HI: begin
        if (accept) begin
          if (n_len == 16'd0)              state_nx = ST_AFTER_DATA;
          else if ({1'b0, n_len} > DEPTH)  state_nx = ST_ERROR;
          else                             state_nx = ST_DATA;
        end
      end
      ST_DATA: if (accept && last_word) state_nx = ST_AFTER_DATA;
`ifdef IMEM_LOADER_CKSUM_EN
      ST_CKSUM: if (accept) state_nx = (in_data == csum) ? ST_RUN : ST_ERROR;
`endif
      ST_RUN: begin
        done      = 1'b1;
        cpu_reset = imem_we;
      end
      ST_ERROR: err = 1'b1;
      default:  state_nx = ST_ERROR;
    endcase
  end

  // Datapath: length capture, word assembly and the registered memory write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed      <= 1'b0;
      len_lo     <= 8'd0;
      byte_cnt   <= 2'd0;
      shreg      <= 24'd0;
      word_index <= '0;
      last_idx   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= 32'd0;
      imem_wdata <= 32'd0;
`ifdef IMEM_LOADER_CKSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      armed   <= 1'b1;
      imem_we <= 1'b0;
      if (accept) begin
        case (state)
          ST_LEN_LO: len_lo <= in_data;
          ST_LEN_HI: last_idx <= ADDR_W'(n_len - 16'd1);
          ST_DATA: begin
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CKSUM_EN
            csum     <= csum ^ in_data;
`endif
            if (byte_cnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_wdata <= {in_data, shreg};
              imem_addr  <= 32'({word_index, 2'b00});
              word_index <= word_index + ADDR_W'(1);
            end else begin
              shreg <= {in_data, shreg[23:8]};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized and directed self-checking bench for imem_loader
module tb_imem_loader;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [7:0] bq_t[$];
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'd0;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        err;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  wr_t  got[$];
  wr_t  exp_w[$];
  bit   exp_run;
  int   last_we_cyc = -1;
  int   fall_cyc = -1;
  int   overlap = 0;
  logic prev_cr = 1'b1;

  always @(posedge clk) cyc++;

  // Capture every write and the cpu_reset release, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset && imem_we === 1'b1) begin
      got.push_back('{imem_addr, imem_wdata});
      last_we_cyc = cyc;
      if (cpu_reset !== 1'b1) overlap++;
    end
    if (reset && prev_cr === 1'b1 && cpu_reset === 1'b0) fall_cyc = cyc;
    prev_cr = cpu_reset;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Reference: expected writes and outcome derived directly from the stream format.
  task automatic model(input bq_t b);
    int n;
    logic [7:0] x;
    exp_w.delete();
    n = int'(b[0]) + 256 * int'(b[1]);
    exp_run = 1'b0;
    if (n > DEPTH) return;
    x = 8'd0;
    for (int w = 0; w < n; w++) begin
      exp_w.push_back('{32'(4 * w), {b[2+4*w+3], b[2+4*w+2], b[2+4*w+1], b[2+4*w]}});
      for (int k = 0; k < 4; k++) x = x ^ b[2+4*w+k];
    end
`ifdef IMEM_LOADER_CKSUM_EN
    exp_run = (b[2+4*n] == x);
`else
    exp_run = 1'b1;
`endif
  endtask

  function automatic bq_t with_ck(input bq_t b);
    bq_t r;
    logic [7:0] x;
    r = b;
    x = 8'd0;
    for (int i = 2; i < b.size(); i++) x = x ^ b[i];
`ifdef IMEM_LOADER_CKSUM_EN
    r.push_back(x);
`endif
    return r;
  endfunction

  task automatic make_stream(input int n, input bit corrupt, output bq_t b);
    logic [7:0] d;
    logic [7:0] x;
    b = {};
    x = 8'd0;
    b.push_back(8'(n));
    b.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) begin
      d = 8'($urandom);
      b.push_back(d);
      x = x ^ d;
    end
`ifdef IMEM_LOADER_CKSUM_EN
    b.push_back(corrupt ? (x ^ 8'($urandom_range(1, 255))) : x);
`else
    if (corrupt) b.push_back(8'hEE);
`endif
  endtask

  // mode 0: back-to-back, 1: idle cycle before every byte, 2: random idles.
  task automatic send(input bq_t b, input int mode);
    bit ok;
    for (int i = 0; i < b.size(); i++) begin
      if (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b[i];
      ok = in_ready;
      @(negedge clk);
      if (!ok) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    got.delete();
    overlap = 0;
    fall_cyc = -1;
    last_we_cyc = -1;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_load(input string tag, input bq_t b);
    model(b);
    repeat (3) @(negedge clk);
    check({tag, ".nwr"}, 32'(got.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < got.size(); i++) begin
      check($sformatf("%s.wr%0d.addr", tag, i), got[i].addr, exp_w[i].addr);
      check($sformatf("%s.wr%0d.data", tag, i), got[i].data, exp_w[i].data);
    end
    check({tag, ".done"}, 32'(done), 32'(exp_run));
    check({tag, ".err"}, 32'(err), 32'(!exp_run));
    check({tag, ".cpu_reset"}, 32'(cpu_reset), 32'(!exp_run));
    check({tag, ".in_ready"}, 32'(in_ready), 32'd0);
    check({tag, ".overlap"}, 32'(overlap), 32'd0);
    if (exp_run && exp_w.size() > 0)
      check({tag, ".fall"}, 32'(fall_cyc), 32'(last_we_cyc + 1));
  endtask

  initial begin
    bq_t b;
    bit  corrupt;

    @(negedge clk);
    @(negedge clk);
    check("rst.in_ready", 32'(in_ready), 32'd0);
    check("rst.imem_we", 32'(imem_we), 32'd0);
    check("rst.imem_addr", imem_addr, 32'd0);
    check("rst.imem_wdata", imem_wdata, 32'd0);
    check("rst.cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst.done", 32'(done), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    reset = 1'b1;
    #1;
    check("rel.in_ready_before_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("rel.in_ready_after_edge", 32'(in_ready), 32'd1);

    b = with_ck('{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD});
    do_reset();
    send(b, 0);
    check_load("b2b", b);

    do_reset();
    send(b, 1);
    check_load("toggle", b);

    b = '{8'h01, 8'h01};
    do_reset();
    send(b, 0);
    check_load("n257", b);

    do_reset();
    send('{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66}, 0);
    check("abort.pre_writes", 32'(got.size()), 32'd1);
    do_reset();
    b = with_ck('{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04});
    send(b, 0);
    check_load("after_abort", b);

`ifdef IMEM_LOADER_CKSUM_EN
    b = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    do_reset();
    send(b, 0);
    check_load("ck_good", b);
    b = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    do_reset();
    send(b, 0);
    check_load("ck_bad", b);
`endif

    b = with_ck('{8'h00, 8'h00});
    do_reset();
    send(b, 0);
    check_load("n0", b);

    make_stream(DEPTH, 1'b0, b);
    do_reset();
    send(b, 0);
    check_load("full", b);

    for (int it = 0; it < 8; it++) begin
`ifdef IMEM_LOADER_CKSUM_EN
      corrupt = ($urandom_range(0, 2) == 0);
`else
      corrupt = 1'b0;
`endif
      make_stream($urandom_range(1, 6), corrupt, b);
      do_reset();
      send(b, int'($urandom_range(0, 2)));
      check_load($sformatf("rnd%0d", it), b);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
